adder_core: RTL and testbench
=============================

Name: adder_core

Overview:
- Registered two-operand integer adder/subtractor used by the MIPS datapath for address and offset arithmetic (PC increment, branch target).
- Combinational core is an explicit carry-lookahead adder built from 4-bit CLA groups; all results are registered with 1-cycle latency.
- Exposes carry, signed overflow and zero flags, plus a simple valid strobe so downstream stages can qualify results.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 (one CLA group per nibble).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands on a/b/sub are valid this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out  output  WIDTH  registered result
- out_valid  output  1  out and flags hold a result captured from an in_valid cycle
- carry_out  output  1  carry out of MSB (for subtract: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  out == 0

Behaviour:
- Single clock domain; all state updates on rising clk edge only.
- Reset is synchronous and active-low. When rst_n=0 at a clock edge: out=0, out_valid=0, carry_out=0, overflow=0, zero=1. No async path; a reset deassertion takes effect at the next edge.
- Core arithmetic (combinational): b_eff = sub ? ~b : b; cin = sub; {c, s} = a + b_eff + cin, computed over WIDTH+1 bits.
- CLA structure: per-bit generate g=a&b_eff, propagate p=a^b_eff. Per 4-bit group: internal carries from g/p/cin, group G and P. Group carries chained via lookahead from group G/P. Sum bit = p ^ carry-in of that bit. A ripple implementation is functionally equivalent and acceptable to verify against, but the delivered RTL uses the CLA form.
- Result wraps modulo 2^WIDTH. There is no saturation.
- overflow = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]).
- zero = (s == 0).
- Latency is exactly 1 cycle.
  - If in_valid=1 at edge N (rst_n=1), out/flags reflect a,b,sub sampled at edge N, and out_valid=1 after edge N.
  - If in_valid=0 at an edge, out and flags hold their previous values and out_valid goes 0.
- No backpressure; a new operation may be issued every cycle (full throughput).
- Reset asserted in the same cycle as in_valid=1: reset wins, the operation is discarded, outputs take reset values.
- Inputs carrying X while in_valid=0 must not disturb the outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with a=0, b=0 -> out=0, out_valid=0, zero=1, carry_out=0, overflow=0. Release rst_n, in_valid=1, a=0, b=0, sub=0 -> next cycle out=0, zero=1, out_valid=1.
- Unsigned wrap: a=200, b=100, sub=0 -> out=44, carry_out=1, overflow=0, zero=0. Then a=255, b=1 -> out=0, carry_out=1, zero=1.
- Signed overflow: a=127, b=1, sub=0 -> out=128, overflow=1, carry_out=0. Then a=128, b=128 -> out=0, overflow=1, carry_out=1, zero=1.
- Subtract: a=5, b=7, sub=1 -> out=254, carry_out=0, overflow=0. Then a=7, b=5, sub=1 -> out=2, carry_out=1. Then a=128, b=1, sub=1 -> out=127, overflow=1.
- Throughput/hold: back-to-back in_valid for 3 cycles, (1+2, 3+4, 10-3) -> out=3, 7, 7 on consecutive cycles with out_valid=1. Then in_valid=0 with a/b changing -> out stays 7, out_valid=0.
- Reset mid-stream: in_valid=1, a=50, b=60, with rst_n=0 on the same edge -> out=0, out_valid=0, zero=1. Also run a random check of 1000 vectors against a behavioural reference for both sub values.

Source files
------------

// File: rtl/adder_core.sv
// Registered WIDTH-bit adder/subtractor built from 4-bit carry-lookahead groups.
// The result and its carry/overflow/zero flags are registered with one cycle of latency.
module adder_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] sum_s;
    logic [NGRP-1:0]  grp_g_s;
    logic [NGRP-1:0]  grp_p_s;
    logic [NGRP:0]    grp_c_s;
    logic [5:0]       cla_s;
    logic             term_s;
    logic             acc_s;
    logic             ovf_s;

    // One 4-bit lookahead group: returns {group G, group P, carry into bits 3..0}.
    function automatic logic [5:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
        logic [3:0] c;
        logic       gg;
        logic       pp;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp   = &p;
        return {gg, pp, c};
    endfunction

    // Combinational CLA: bit g/p, group G/P, flat group lookahead, then per-bit carries and sum.
    always_comb begin
        b_eff_s = sub ? ~b : b;
        g_s     = a & b_eff_s;
        p_s     = a ^ b_eff_s;
        grp_g_s = {NGRP{1'b0}};
        grp_p_s = {NGRP{1'b0}};
        grp_c_s = {(NGRP + 1){1'b0}};
        c_s     = {WIDTH{1'b0}};
        cla_s   = 6'd0;
        term_s  = 1'b0;
        acc_s   = 1'b0;

        // Group G/P are independent of the group carry-in.
        for (int i = 0; i < NGRP; i++) begin
            cla_s      = cla4(g_s[4*i +: 4], p_s[4*i +: 4], 1'b0);
            grp_g_s[i] = cla_s[5];
            grp_p_s[i] = cla_s[4];
        end

        // Each group carry is a sum of products of earlier G/P and cin, not a chain.
        for (int k = 0; k <= NGRP; k++) begin
            term_s = sub;
            for (int m = 0; m < k; m++) begin
                term_s = term_s & grp_p_s[m];
            end
            acc_s = term_s;
            for (int j = 0; j < k; j++) begin
                term_s = grp_g_s[j];
                for (int m = j + 1; m < k; m++) begin
                    term_s = term_s & grp_p_s[m];
                end
                acc_s = acc_s | term_s;
            end
            grp_c_s[k] = acc_s;
        end

        for (int i = 0; i < NGRP; i++) begin
            cla_s          = cla4(g_s[4*i +: 4], p_s[4*i +: 4], grp_c_s[i]);
            c_s[4*i +: 4]  = cla_s[3:0];
        end

        sum_s = p_s ^ c_s;
        ovf_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    end

    // Output registers: reset wins, a valid operation loads, otherwise hold with out_valid low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= {WIDTH{1'b0}};
            out_valid <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else if (in_valid) begin
            out       <= sum_s;
            out_valid <= 1'b1;
            carry_out <= grp_c_s[NGRP];
            overflow  <= ovf_s;
            zero      <= (sum_s == {WIDTH{1'b0}});
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_core.sv
// Directed and randomized self-checking bench for adder_core (WIDTH=8).
// Observed state is packed as {out, out_valid, carry_out, overflow, zero}.
module tb_adder_core;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] out;
    logic       out_valid;
    logic       carry_out;
    logic       overflow;
    logic       zero;

    int n_cmp;
    int n_bad;

    adder_core #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out       (out),
        .out_valid (out_valid),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [11:0] obs;
        rst_n = 1'b0; in_valid = 1'b0; a = 8'd0; b = 8'd0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {out, out_valid, carry_out, overflow, zero};
        n_cmp++;
        if (obs !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: actual=%h required=%h", obs, {8'd0, 4'b0001});
        end
        rst_n = 1'b1; in_valid = 1'b1; a = 8'd0; b = 8'd0; sub = 1'b0;
        @(posedge clk); #1;
        obs = {out, out_valid, carry_out, overflow, zero};
        n_cmp++;
        if (obs !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_first_op: actual=%h required=%h", obs, {8'd0, 4'b1001});
        end
    endtask

    task automatic test_directed();
        logic [7:0]  va [7];
        logic [7:0]  vb [7];
        logic        vs [7];
        logic [11:0] ve [7];
        logic [11:0] obs;
        // Hand-computed: out, valid, carry, overflow, zero.
        va = '{8'd200, 8'd255, 8'd127, 8'd128, 8'd5,   8'd7,  8'd128};
        vb = '{8'd100, 8'd1,   8'd1,   8'd128, 8'd7,   8'd5,  8'd1};
        vs = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b1,  1'b1};
        ve = '{{8'd44,  4'b1100},
               {8'd0,   4'b1101},
               {8'd128, 4'b1010},
               {8'd0,   4'b1111},
               {8'd254, 4'b1000},
               {8'd2,   4'b1100},
               {8'd127, 4'b1110}};
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i];
            @(posedge clk); #1;
            obs = {out, out_valid, carry_out, overflow, zero};
            n_cmp++;
            if (obs !== ve[i]) begin
                n_bad++;
                $display("FAIL directed[%0d] a=%0d b=%0d sub=%0b: actual=%h required=%h",
                         i, va[i], vb[i], vs[i], obs, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic        vs [3];
        logic [11:0] ve [3];
        logic [11:0] obs;
        va = '{8'd1, 8'd3, 8'd10};
        vb = '{8'd2, 8'd4, 8'd3};
        vs = '{1'b0, 1'b0, 1'b1};
        ve = '{{8'd3, 4'b1000}, {8'd7, 4'b1000}, {8'd7, 4'b1100}};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i];
            @(posedge clk); #1;
            obs = {out, out_valid, carry_out, overflow, zero};
            n_cmp++;
            if (obs !== ve[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d]: actual=%h required=%h", i, obs, ve[i]);
            end
        end
        // Idle cycles with changing and then unknown operands must only drop out_valid.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            if (i == 2) begin
                a = 8'bx; b = 8'bx; sub = 1'bx;
            end else begin
                a = 8'd99 + 8'(i); b = 8'd200; sub = 1'b0;
            end
            @(posedge clk); #1;
            obs = {out, out_valid, carry_out, overflow, zero};
            n_cmp++;
            if (obs !== {8'd7, 4'b0100}) begin
                n_bad++;
                $display("FAIL hold[%0d]: actual=%h required=%h", i, obs, {8'd7, 4'b0100});
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [11:0] obs;
        in_valid = 1'b1; a = 8'd9; b = 8'd9; sub = 1'b0;
        @(posedge clk); #1;
        obs = {out, out_valid, carry_out, overflow, zero};
        n_cmp++;
        if (obs !== {8'd18, 4'b1000}) begin
            n_bad++;
            $display("FAIL pre_reset_op: actual=%h required=%h", obs, {8'd18, 4'b1000});
        end
        rst_n = 1'b0; in_valid = 1'b1; a = 8'd50; b = 8'd60; sub = 1'b0;
        @(posedge clk); #1;
        obs = {out, out_valid, carry_out, overflow, zero};
        n_cmp++;
        if (obs !== {8'd0, 4'b0001}) begin
            n_bad++;
            $display("FAIL reset_wins: actual=%h required=%h", obs, {8'd0, 4'b0001});
        end
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [11:0] obs;
        logic [11:0] exp;
        logic [8:0]  full;
        logic [7:0]  be;
        logic        iv;
        exp = {out, out_valid, carry_out, overflow, zero};
        exp[3] = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            sub = 1'($urandom_range(0, 1));
            in_valid = iv;
            if (iv) begin
                be   = sub ? ~b : b;
                full = {1'b0, a} + {1'b0, be} + {8'd0, sub};
                exp  = {full[7:0], 1'b1, full[8],
                        (a[7] == be[7]) && (full[7] != a[7]),
                        (full[7:0] == 8'd0)};
            end else begin
                exp[3] = 1'b0;
            end
            @(posedge clk); #1;
            obs = {out, out_valid, carry_out, overflow, zero};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL random[%0d] iv=%0b a=%0d b=%0d sub=%0b: actual=%h required=%h",
                         i, iv, a, b, sub, obs, exp);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = 8'd0; b = 8'd0; sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
